// File: rtl/dma_bank_pkg.sv
// Shared definitions for the DMA channel bank: register selector encoding,
// mode bit positions and an index-width helper that never returns zero.
package dma_bank_pkg;

    typedef enum logic [1:0] {
        SEL_ADDR   = 2'd0,
        SEL_COUNT  = 2'd1,
        SEL_MODE   = 2'd2,
        SEL_STATUS = 2'd3
    } regsel_e;

    localparam int MODE_AUTOINIT_BIT = 4;
    localparam int MODE_DEC_BIT      = 5;

    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/dma_chan_regs.sv
// One DMA channel: base/current address and count, mode byte, and the
// per-transfer advance with optional auto-init reload on terminal count.
module dma_chan_regs
    import dma_bank_pkg::*;
#(
    parameter  int ADDR_W = 16,
    localparam int BYTES  = ADDR_W / 8,
    localparam int PTR_W  = idx_w(BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_addr,
    input  logic              wr_count,
    input  logic              wr_mode,
    input  logic [PTR_W-1:0]  byte_sel,
    input  logic [7:0]        wr_data,
    input  logic              step,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] cur_count,
    output logic [7:0]        mode,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] base_addr_r;
    logic [ADDR_W-1:0] base_count_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] cur_count_r;
    logic [7:0]        mode_r;

    // A step that finds the count already at zero is the terminal transfer.
    assign tc        = step && (cur_count_r == {ADDR_W{1'b0}});
    assign cur_addr  = cur_addr_r;
    assign cur_count = cur_count_r;
    assign mode      = mode_r;

    // Register update: CPU byte loads win over a step on this channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_addr_r  <= {ADDR_W{1'b0}};
            base_count_r <= {ADDR_W{1'b0}};
            cur_addr_r   <= {ADDR_W{1'b0}};
            cur_count_r  <= {ADDR_W{1'b0}};
            mode_r       <= 8'h00;
        end else begin
            if (wr_addr) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_sel == PTR_W'(b)) begin
                        base_addr_r[b*8 +: 8] <= wr_data;
                        cur_addr_r[b*8 +: 8]  <= wr_data;
                    end
                end
            end else if (wr_count) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_sel == PTR_W'(b)) begin
                        base_count_r[b*8 +: 8] <= wr_data;
                        cur_count_r[b*8 +: 8]  <= wr_data;
                    end
                end
            end else if (step) begin
                if (tc && mode_r[MODE_AUTOINIT_BIT]) begin
                    cur_addr_r  <= base_addr_r;
                    cur_count_r <= base_count_r;
                end else begin
                    cur_addr_r  <= mode_r[MODE_DEC_BIT] ? (cur_addr_r - ONE) : (cur_addr_r + ONE);
                    cur_count_r <= cur_count_r - ONE;
                end
            end
            if (wr_mode) begin
                mode_r <= wr_data;
            end
        end
    end

endmodule

// File: rtl/dma_channel_bank.sv
// Bank of DMA channel register sets behind a byte-wide CPU port with a shared
// byte pointer, plus transfer stepping and sticky terminal-count status.
module dma_channel_bank
    import dma_bank_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int ADDR_W = 16,
    localparam int CH_W   = idx_w(NUM_CH),
    localparam int BYTES  = ADDR_W / 8,
    localparam int PTR_W  = idx_w(BYTES)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MasterClear,
    input  logic              RegWr,
    input  logic              RegRd,
    input  logic [CH_W-1:0]   RegCh,
    input  logic [1:0]        RegSel,
    input  logic [7:0]        DataIn,
    output logic [7:0]        DataOut,
    input  logic              ClearFF,
    input  logic              Step,
    input  logic [CH_W-1:0]   StepCh,
    output logic [ADDR_W-1:0] ActAddr,
    output logic [NUM_CH-1:0] TCPulse
);

    logic              rst_s;
    regsel_e           sel_s;
    logic              byte_acc_s;
    logic              rd_status_s;
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  eff_ptr_s;
    logic [ADDR_W-1:0] cur_addr_s  [NUM_CH];
    logic [ADDR_W-1:0] cur_count_s [NUM_CH];
    logic [7:0]        mode_s      [NUM_CH];
    logic [NUM_CH-1:0] tc_s;
    logic [NUM_CH-1:0] sticky_r;
    logic [NUM_CH-1:0] tc_pulse_r;
    logic [7:0]        status_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] rd_count_s;
    logic [7:0]        rd_mode_s;
    logic [7:0]        rd_addr_byte_s;
    logic [7:0]        rd_count_byte_s;
    logic [7:0]        dout_s;
    logic [ADDR_W-1:0] act_addr_s;

    assign rst_s       = Reset || MasterClear;
    assign sel_s       = regsel_e'(RegSel);
    assign byte_acc_s  = (RegWr || RegRd) && ((sel_s == SEL_ADDR) || (sel_s == SEL_COUNT));
    assign rd_status_s = RegRd && (sel_s == SEL_STATUS);
    // ClearFF acts in the same cycle, so an access alongside it uses byte 0.
    assign eff_ptr_s   = ClearFF ? {PTR_W{1'b0}} : ptr_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit_s;
        logic wr_addr_s;
        logic wr_count_s;
        logic wr_mode_s;
        logic step_s;

        assign hit_s      = RegWr && (RegCh == CH_W'(i));
        assign wr_addr_s  = hit_s && (sel_s == SEL_ADDR);
        assign wr_count_s = hit_s && (sel_s == SEL_COUNT);
        assign wr_mode_s  = hit_s && (sel_s == SEL_MODE);
        // An ADDR/COUNT load to this channel swallows a coincident step.
        assign step_s     = Step && (StepCh == CH_W'(i)) && !wr_addr_s && !wr_count_s;

        dma_chan_regs #(
            .ADDR_W (ADDR_W)
        ) u_regs (
            .clk       (Clock),
            .rst       (rst_s),
            .wr_addr   (wr_addr_s),
            .wr_count  (wr_count_s),
            .wr_mode   (wr_mode_s),
            .byte_sel  (eff_ptr_s),
            .wr_data   (DataIn),
            .step      (step_s),
            .cur_addr  (cur_addr_s[i]),
            .cur_count (cur_count_s[i]),
            .mode      (mode_s[i]),
            .tc        (tc_s[i])
        );
    end

    // Shared byte pointer: advances on every ADDR/COUNT access, wraps at BYTES.
    always_ff @(posedge Clock) begin
        if (rst_s) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (byte_acc_s) begin
            ptr_r <= (eff_ptr_s == PTR_W'(BYTES - 1)) ? {PTR_W{1'b0}} : (eff_ptr_s + PTR_W'(1));
        end else if (ClearFF) begin
            ptr_r <= {PTR_W{1'b0}};
        end
    end

    // Terminal-count pulse and sticky status; a new TC beats a status-read clear.
    always_ff @(posedge Clock) begin
        if (rst_s) begin
            tc_pulse_r <= {NUM_CH{1'b0}};
            sticky_r   <= {NUM_CH{1'b0}};
        end else begin
            tc_pulse_r <= tc_s;
            sticky_r   <= (rd_status_s ? {NUM_CH{1'b0}} : sticky_r) | tc_s;
        end
    end

    // Channel muxes for the CPU read path and the active address.
    always_comb begin
        rd_addr_s  = {ADDR_W{1'b0}};
        rd_count_s = {ADDR_W{1'b0}};
        rd_mode_s  = 8'h00;
        act_addr_s = {ADDR_W{1'b0}};
        status_s   = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_addr_s   = rd_addr_s  | ({ADDR_W{RegCh == CH_W'(i)}} & cur_addr_s[i]);
            rd_count_s  = rd_count_s | ({ADDR_W{RegCh == CH_W'(i)}} & cur_count_s[i]);
            rd_mode_s   = rd_mode_s  | ({8{RegCh == CH_W'(i)}} & mode_s[i]);
            act_addr_s  = act_addr_s | ({ADDR_W{StepCh == CH_W'(i)}} & cur_addr_s[i]);
            status_s[i] = sticky_r[i];
        end
    end

    // Byte selection and register-select decode for DataOut.
    always_comb begin
        rd_addr_byte_s  = 8'h00;
        rd_count_byte_s = 8'h00;
        for (int b = 0; b < BYTES; b++) begin
            rd_addr_byte_s  = rd_addr_byte_s  | ({8{eff_ptr_s == PTR_W'(b)}} & rd_addr_s[b*8 +: 8]);
            rd_count_byte_s = rd_count_byte_s | ({8{eff_ptr_s == PTR_W'(b)}} & rd_count_s[b*8 +: 8]);
        end
        dout_s = 8'h00;
        if (RegRd) begin
            case (sel_s)
                SEL_ADDR:   dout_s = rd_addr_byte_s;
                SEL_COUNT:  dout_s = rd_count_byte_s;
                SEL_MODE:   dout_s = rd_mode_s;
                SEL_STATUS: dout_s = status_s;
                default:    dout_s = 8'h00;
            endcase
        end else begin
            dout_s = 8'h00;
        end
    end

    assign DataOut = dout_s;
    assign ActAddr = act_addr_s;
    assign TCPulse = tc_pulse_r;

endmodule

// File: tb/tb_dma_channel_bank.sv
// Directed bench for dma_channel_bank: a rule-level model of a 4-channel
// 16-bit bank checked every cycle, plus a 8-channel 24-bit reset scenario.
module tb_dma_channel_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mclr, wr, rd, clrff, step;
    logic [1:0] ch, sel, stepch;
    logic [7:0] din, dout;
    logic [15:0] act;
    logic [3:0] tcp;

    logic       b_rst, b_mclr, b_wr, b_rd, b_clrff, b_step;
    logic [2:0] b_ch, b_stepch;
    logic [1:0] b_sel;
    logic [7:0] b_din, b_dout;
    logic [23:0] b_act;
    logic [7:0] b_tcp;

    dma_channel_bank #(.NUM_CH(4), .ADDR_W(16)) dut_a (
        .Clock(clk), .Reset(rst), .MasterClear(mclr), .RegWr(wr), .RegRd(rd),
        .RegCh(ch), .RegSel(sel), .DataIn(din), .DataOut(dout), .ClearFF(clrff),
        .Step(step), .StepCh(stepch), .ActAddr(act), .TCPulse(tcp)
    );

    dma_channel_bank #(.NUM_CH(8), .ADDR_W(24)) dut_b (
        .Clock(clk), .Reset(b_rst), .MasterClear(b_mclr), .RegWr(b_wr), .RegRd(b_rd),
        .RegCh(b_ch), .RegSel(b_sel), .DataIn(b_din), .DataOut(b_dout), .ClearFF(b_clrff),
        .Step(b_step), .StepCh(b_stepch), .ActAddr(b_act), .TCPulse(b_tcp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act_v, exp_v);
        end
    endtask

    // Behavioural model of the 4-channel, 2-byte bank.
    logic [15:0] m_base_addr [4];
    logic [15:0] m_cur_addr  [4];
    logic [15:0] m_base_cnt  [4];
    logic [15:0] m_cur_cnt   [4];
    logic [7:0]  m_mode      [4];
    logic [3:0]  m_sticky;
    logic [3:0]  m_tcp;
    int          m_ptr;
    bit          m_valid = 1'b0;

    task automatic model_tick();
        logic [3:0] tc;
        int p;
        int sc;
        int c;
        if (rst || mclr) begin
            for (int i = 0; i < 4; i++) begin
                m_base_addr[i] = 16'h0; m_cur_addr[i] = 16'h0;
                m_base_cnt[i]  = 16'h0; m_cur_cnt[i]  = 16'h0;
                m_mode[i]      = 8'h00;
            end
            m_ptr = 0; m_sticky = 4'h0; m_tcp = 4'h0; m_valid = 1'b1;
        end else begin
            tc = 4'h0;
            p  = clrff ? 0 : m_ptr;
            sc = int'(stepch);
            c  = int'(ch);
            if (step && !(wr && sel < 2'd2 && ch == stepch)) begin
                if (m_cur_cnt[sc] == 16'h0) tc[sc] = 1'b1;
                if (tc[sc] && m_mode[sc][4]) begin
                    m_cur_addr[sc] = m_base_addr[sc];
                    m_cur_cnt[sc]  = m_base_cnt[sc];
                end else begin
                    m_cur_addr[sc] = m_mode[sc][5] ? m_cur_addr[sc] - 16'd1 : m_cur_addr[sc] + 16'd1;
                    m_cur_cnt[sc]  = m_cur_cnt[sc] - 16'd1;
                end
            end
            if (wr) begin
                case (sel)
                    2'd0: begin m_base_addr[c][p*8 +: 8] = din; m_cur_addr[c][p*8 +: 8] = din; end
                    2'd1: begin m_base_cnt[c][p*8 +: 8]  = din; m_cur_cnt[c][p*8 +: 8]  = din; end
                    2'd2: m_mode[c] = din;
                    default: ;
                endcase
            end
            m_sticky = ((rd && sel == 2'd3) ? 4'h0 : m_sticky) | tc;
            m_tcp    = tc;
            if ((wr || rd) && sel < 2'd2) m_ptr = (p + 1) % 2;
            else if (clrff) m_ptr = 0;
        end
    endtask

    function automatic logic [7:0] exp_dout();
        int p = clrff ? 0 : m_ptr;
        int c = int'(ch);
        if (!rd) return 8'h00;
        case (sel)
            2'd0:    return m_cur_addr[c][p*8 +: 8];
            2'd1:    return m_cur_cnt[c][p*8 +: 8];
            2'd2:    return m_mode[c];
            default: return {4'h0, m_sticky};
        endcase
    endfunction

    // Every-cycle comparison of dut_a against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_dataout", 32'(dout), 32'(exp_dout()));
            chk("model_actaddr", 32'(act), 32'(m_cur_addr[int'(stepch)]));
            chk("model_tcpulse", 32'(tcp), 32'(m_tcp));
        end
    end

    task automatic half_a();
        @(negedge clk); #1;
    endtask

    task automatic half_b();
        model_tick(); @(posedge clk); #1;
    endtask

    task automatic run_cycle();
        half_a(); half_b();
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0; clrff = 1'b0; step = 1'b0; rst = 1'b0; mclr = 1'b0; din = 8'h00;
        b_wr = 1'b0; b_rd = 1'b0; b_clrff = 1'b0; b_step = 1'b0; b_rst = 1'b0; b_mclr = 1'b0; b_din = 8'h00;
    endtask

    task automatic cpu_wr(input logic [1:0] c, input logic [1:0] s, input logic [7:0] d, input logic cf);
        ch = c; sel = s; din = d; clrff = cf; wr = 1'b1;
        run_cycle(); idle();
    endtask

    task automatic cpu_rd(input logic [1:0] c, input logic [1:0] s, input logic cf,
                          input logic [7:0] exp_v, input string name);
        ch = c; sel = s; clrff = cf; rd = 1'b1;
        half_a(); chk(name, 32'(dout), 32'(exp_v)); half_b(); idle();
    endtask

    task automatic do_step(input logic [1:0] c);
        step = 1'b1; stepch = c;
        run_cycle(); idle();
    endtask

    task automatic chk_tcp(input logic [3:0] exp_v, input string name);
        half_a(); chk(name, 32'(tcp), 32'(exp_v)); half_b();
    endtask

    task automatic chk_act(input logic [1:0] c, input logic [15:0] exp_v, input string name);
        stepch = c; half_a(); chk(name, 32'(act), 32'(exp_v)); half_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        ch = 2'd0; sel = 2'd0; stepch = 2'd0; b_ch = 3'd0; b_sel = 2'd0; b_stepch = 3'd0;
        rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;
        run_cycle(); run_cycle(); idle();

        cpu_rd(2'd0, 2'd3, 1'b0, 8'h00, "reset_status");
        cpu_rd(2'd1, 2'd0, 1'b1, 8'h00, "reset_addr");

        // Byte-pointer sequencing on ch2.
        clrff = 1'b1; run_cycle(); idle();
        cpu_wr(2'd2, 2'd0, 8'h34, 1'b0);
        cpu_wr(2'd2, 2'd0, 8'h12, 1'b0);
        cpu_rd(2'd2, 2'd0, 1'b1, 8'h34, "ch2_addr_lo");
        cpu_rd(2'd2, 2'd0, 1'b0, 8'h12, "ch2_addr_hi");
        chk_act(2'd2, 16'h1234, "ch2_actaddr");

        // Ch1 counts down to terminal count.
        cpu_wr(2'd1, 2'd1, 8'h01, 1'b1);
        cpu_wr(2'd1, 2'd1, 8'h00, 1'b0);
        cpu_wr(2'd1, 2'd2, 8'h00, 1'b0);
        cpu_wr(2'd1, 2'd0, 8'hFF, 1'b1);
        cpu_wr(2'd1, 2'd0, 8'h00, 1'b0);
        do_step(2'd1);
        chk_tcp(4'b0000, "tc1_not_yet");
        do_step(2'd1);
        chk_tcp(4'b0010, "tc1_pulse");
        chk_tcp(4'b0000, "tc1_pulse_end");
        cpu_rd(2'd1, 2'd0, 1'b1, 8'h01, "ch1_addr_lo");
        cpu_rd(2'd1, 2'd0, 1'b0, 8'h01, "ch1_addr_hi");
        cpu_rd(2'd1, 2'd1, 1'b1, 8'hFF, "ch1_cnt_lo");
        cpu_rd(2'd1, 2'd1, 1'b0, 8'hFF, "ch1_cnt_hi");
        cpu_rd(2'd1, 2'd3, 1'b0, 8'h02, "status_ch1");
        cpu_rd(2'd1, 2'd3, 1'b0, 8'h00, "status_cleared");

        // Ch0 auto-init reload.
        cpu_wr(2'd0, 2'd2, 8'h10, 1'b0);
        cpu_wr(2'd0, 2'd0, 8'h00, 1'b1);
        cpu_wr(2'd0, 2'd0, 8'h10, 1'b0);
        cpu_wr(2'd0, 2'd1, 8'h00, 1'b1);
        cpu_wr(2'd0, 2'd1, 8'h00, 1'b0);
        do_step(2'd0);
        chk_tcp(4'b0001, "tc0_autoinit");
        cpu_rd(2'd0, 2'd0, 1'b1, 8'h00, "ch0_reload_addr_lo");
        cpu_rd(2'd0, 2'd0, 1'b0, 8'h10, "ch0_reload_addr_hi");
        cpu_rd(2'd0, 2'd1, 1'b1, 8'h00, "ch0_reload_cnt_lo");
        cpu_rd(2'd0, 2'd1, 1'b0, 8'h00, "ch0_reload_cnt_hi");

        // Ch3 decrement wraps below zero.
        cpu_wr(2'd3, 2'd2, 8'h20, 1'b0);
        cpu_wr(2'd3, 2'd0, 8'h00, 1'b1);
        cpu_wr(2'd3, 2'd0, 8'h00, 1'b0);
        cpu_wr(2'd3, 2'd1, 8'h05, 1'b1);
        cpu_wr(2'd3, 2'd1, 8'h00, 1'b0);
        do_step(2'd3);
        chk_act(2'd3, 16'hFFFF, "dec_wrap");
        cpu_rd(2'd3, 2'd3, 1'b0, 8'h01, "status_ch0");

        // Status read coinciding with a ch3 terminal count.
        cpu_wr(2'd3, 2'd1, 8'h00, 1'b1);
        cpu_wr(2'd3, 2'd1, 8'h00, 1'b0);
        do_step(2'd0);
        ch = 2'd0; sel = 2'd3; rd = 1'b1; step = 1'b1; stepch = 2'd3;
        half_a(); chk("status_during_tc", 32'(dout), 32'(8'h01)); half_b(); idle();
        cpu_rd(2'd0, 2'd3, 1'b0, 8'h08, "status_set_wins");

        // COUNT write and step on the same channel: step dropped.
        ch = 2'd2; sel = 2'd1; din = 8'h07; clrff = 1'b1; wr = 1'b1; step = 1'b1; stepch = 2'd2;
        run_cycle(); idle();
        chk_tcp(4'b0000, "collide_no_tc");
        chk_act(2'd2, 16'h1234, "collide_no_step");

        // Step and CPU access on different channels in the same cycle.
        ch = 2'd2; sel = 2'd2; din = 8'h00; wr = 1'b1; step = 1'b1; stepch = 2'd1;
        run_cycle(); idle();
        chk_act(2'd1, 16'h0102, "indep_step");

        // MasterClear beats a simultaneous write.
        mclr = 1'b1; ch = 2'd1; sel = 2'd0; din = 8'h55; wr = 1'b1;
        run_cycle(); idle();
        cpu_rd(2'd1, 2'd0, 1'b0, 8'h00, "mclr_addr");
        chk_act(2'd2, 16'h0000, "mclr_actaddr");
        cpu_rd(2'd1, 2'd2, 1'b0, 8'h00, "mclr_mode");

        // Wide bank: reset drops a partially written address and the pointer.
        b_ch = 3'd5; b_sel = 2'd0; b_stepch = 3'd5; b_wr = 1'b1;
        b_clrff = 1'b1; b_din = 8'h11; run_cycle();
        b_clrff = 1'b0; b_din = 8'h22; run_cycle();
        b_din = 8'h33; run_cycle();
        b_wr = 1'b0;
        half_a(); chk("b_addr_full", 32'(b_act), 32'(24'h332211)); half_b();
        b_wr = 1'b1; b_din = 8'h44; run_cycle();
        b_din = 8'h55; run_cycle();
        b_wr = 1'b0;
        half_a(); chk("b_addr_partial", 32'(b_act), 32'(24'h335544)); half_b();
        b_rst = 1'b1; run_cycle(); b_rst = 1'b0;
        b_rd = 1'b1; b_sel = 2'd3;
        half_a();
        chk("b_reset_addr", 32'(b_act), 32'(24'h000000));
        chk("b_reset_status", 32'(b_dout), 32'(8'h00));
        half_b();
        b_rd = 1'b0; b_sel = 2'd0; b_wr = 1'b1; b_din = 8'h66; run_cycle(); b_wr = 1'b0;
        half_a(); chk("b_first_byte0", 32'(b_act), 32'(24'h000066)); half_b();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
